// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and baud divisor helper,
// used by both uart_tx and uart_rx_core.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA_BITS = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_CLEANUP   = 3'd5
  } uart_state_e;

  // Clock cycles per serial bit; integer division truncates toward zero.
  function automatic int baud_div(input int clk_freq, input int br);
    return clk_freq / br;
  endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous input bit;
// both flops load RST_VAL on reset so the output starts at a known level.
module uart_sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic sync_p0;
  logic sync_p1;

  always_ff @(posedge i_clk) begin
    if (RST) begin
      sync_p0 <= RST_VAL;
      sync_p1 <= RST_VAL;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: start bit, B_PER_T data bits LSB first, stop bit, sampled at
// bit midpoints. Define UART_RX_PARITY_EN to add a parity bit before the stop bit.
module uart_rx_core import uart_pkg::*; #(
  parameter int B_PER_T  = 8,
  parameter int BR       = 9600,
  parameter int CLK_FREQ = 50_000_000
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic               i_clk,
  input  logic               RST,
  input  logic               i_rx,
  output logic [B_PER_T-1:0] o_data,
  output logic               o_dv,
  output logic               o_busy,
  output logic               o_frame_err,
  output logic               o_parity_err
);

  localparam int BD    = baud_div(CLK_FREQ, BR);
  localparam int CNT_W = $clog2(BD);
  localparam int IDX_W = $clog2(B_PER_T);
  localparam int HALF  = (BD - 1) / 2;

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BD - 1);
  localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(B_PER_T - 1);

  if (BD < 4) begin : g_bd_check
    $error("uart_rx_core: CLK_FREQ/BR = %0d, must be >= 4", BD);
  end
  if (B_PER_T < 5 || B_PER_T > 9) begin : g_bits_check
    $error("uart_rx_core: B_PER_T = %0d, must be 5..9", B_PER_T);
  end

  logic rx_s;

  uart_sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .i_clk(i_clk),
    .RST  (RST),
    .d    (i_rx),
    .q    (rx_s)
  );

  uart_state_e        state_q, state_d;
  logic [CNT_W-1:0]   clk_cnt_q, clk_cnt_d;
  logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [B_PER_T-1:0] shift_q;
  logic               shift_we;
  logic               dv_d;
  logic               fe_d;
  logic               par_bad;

`ifdef UART_RX_PARITY_EN
  logic par_we;
  logic pe_d;
  logic par_bad_q;

  assign par_bad = par_bad_q;
`else
  assign par_bad = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_we  = 1'b0;
    dv_d      = 1'b0;
    fe_d      = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_we    = 1'b0;
    pe_d      = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        clk_cnt_d = '0;
        bit_idx_d = '0;
        if (!rx_s) state_d = ST_START;
      end
      // Re-check the start bit at its midpoint to reject short low glitches.
      ST_START: begin
        if (clk_cnt_q == CNT_HALF) begin
          clk_cnt_d = '0;
          state_d   = rx_s ? ST_IDLE : ST_DATA_BITS;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      ST_DATA_BITS: begin
        if (clk_cnt_q == CNT_MAX) begin
          clk_cnt_d = '0;
          shift_we  = 1'b1;
          if (bit_idx_q == IDX_MAX) begin
            bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d   = ST_PARITY;
`else
            state_d   = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (clk_cnt_q == CNT_MAX) begin
          clk_cnt_d = '0;
          par_we    = 1'b1;
          state_d   = ST_STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (clk_cnt_q == CNT_MAX) begin
          clk_cnt_d = '0;
          state_d   = ST_CLEANUP;
          dv_d      = rx_s & ~par_bad;
          fe_d      = ~rx_s;
`ifdef UART_RX_PARITY_EN
          pe_d      = par_bad;
`endif
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      // A line held low (break) must return high before another start is seen.
      ST_CLEANUP: begin
        clk_cnt_d = '0;
        if (rx_s) state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        clk_cnt_d = '0;
        bit_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      o_dv        <= 1'b0;
      o_frame_err <= 1'b0;
      o_data      <= '0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      o_dv        <= dv_d;
      o_frame_err <= fe_d;
      if (dv_d) o_data <= shift_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (shift_we) shift_q[bit_idx_q] <= rx_s;
  end

`ifdef UART_RX_PARITY_EN
  // Mismatch when data plus parity bit does not have the selected parity.
  always_ff @(posedge i_clk) begin
    if (RST) begin
      par_bad_q    <= 1'b0;
      o_parity_err <= 1'b0;
    end else begin
      if (par_we) par_bad_q <= ((^shift_q) ^ rx_s) != PARITY_ODD;
      o_parity_err <= pe_d;
    end
  end
`else
  assign o_parity_err = 1'b0;
`endif

  assign o_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: directed and random frames checked against a
// frame-level expected-event queue.
`timescale 1ns/1ps
module tb_uart_rx_core;

  localparam int B_PER_T  = 8;
  localparam int BR       = 100_000;
  localparam int CLK_FREQ = 1_000_000;
  localparam int BD       = 10;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_BITS   = 1;
  localparam bit PARITY_ODD = 1'b0;
`else
  localparam int PAR_BITS   = 0;
`endif
  // Start edge to o_dv: (data + parity + 1.5) bit times plus 2 sync cycles.
  localparam int LAT_NOM = ((2 * (B_PER_T + PAR_BITS) + 3) * BD) / 2 + 2;

  typedef struct packed {
    logic       dv;
    logic       fe;
    logic       pe;
    logic [7:0] data;
  } evt_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] o_data;
  logic       o_dv, o_busy, o_frame_err, o_parity_err;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   n_evt   = 0;
  int   last_evt_cyc = 0;
  evt_t exp_q[$];
  logic [7:0] model_last = 8'h00;

  uart_rx_core #(
    .B_PER_T (B_PER_T),
    .BR      (BR),
    .CLK_FREQ(CLK_FREQ)
`ifdef UART_RX_PARITY_EN
    , .PARITY_ODD(PARITY_ODD)
`endif
  ) dut (
    .i_clk       (clk),
    .RST         (rst),
    .i_rx        (rx),
    .o_data      (o_data),
    .o_dv        (o_dv),
    .o_busy      (o_busy),
    .o_frame_err (o_frame_err),
    .o_parity_err(o_parity_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every output pulse must match the next expected frame outcome.
  always @(negedge clk) begin
    evt_t e;
    if (!rst && (o_dv || o_frame_err || o_parity_err)) begin
      n_evt++;
      last_evt_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_evt", {29'd0, o_dv, o_frame_err, o_parity_err}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("evt_dv", o_dv, e.dv);
        check("evt_frame_err", o_frame_err, e.fe);
        check("evt_parity_err", o_parity_err, e.pe);
        check("evt_data", o_data, e.data);
      end
    end
  end

  task automatic drive_bit(input logic b, input int n);
    rx = b;
    repeat (n) @(negedge clk);
  endtask

  // Called on a negedge; queues the expected outcome, then drives the frame.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok, input int gap);
    evt_t e;
    e.dv = stop_ok && par_ok;
    e.fe = !stop_ok;
    e.pe = !par_ok;
    if (e.dv) model_last = d;
    e.data = model_last;
    exp_q.push_back(e);
    drive_bit(1'b0, BD);
    for (int i = 0; i < B_PER_T; i++) drive_bit(d[i], BD);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ PARITY_ODD ^ !par_ok, BD);
`endif
    if (stop_ok) drive_bit(1'b1, BD);
    else         drive_bit(1'b0, BD + 20);
    drive_bit(1'b1, gap);
  endtask

  initial begin
    int t0, n0, busy_cnt, gap;
    logic [7:0] d;
    bit sok, pok;

    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data", o_data, 8'h00);
    check("rst_dv", o_dv, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_frame_err", o_frame_err, 1'b0);
    check("rst_parity_err", o_parity_err, 1'b0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Clean frame with latency measurement
    t0 = cyc;
    n0 = n_evt;
    send_frame(8'hA5, 1'b1, 1'b1, 20);
    check("a5_evt_count", n_evt - n0, 1);
    check("a5_latency_ok", ((last_evt_cyc - t0) >= LAT_NOM - 1) && ((last_evt_cyc - t0) <= LAT_NOM + 1), 1);
    check("a5_data_hold", o_data, 8'hA5);

    // Short low glitch on an idle line
    n0 = n_evt;
    busy_cnt = 0;
    rx = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i == 3) rx = 1'b1;
      @(negedge clk);
      if (o_busy) busy_cnt++;
    end
    check("glitch_busy_ok", (busy_cnt >= 1) && (busy_cnt <= 7), 1);
    check("glitch_no_evt", n_evt - n0, 0);
    check("glitch_idle", o_busy, 1'b0);

    // Stop bit low, then a good frame
    n0 = n_evt;
    send_frame(8'h3C, 1'b0, 1'b1, 20);
    send_frame(8'h81, 1'b1, 1'b1, 20);
    check("ferr_evt_count", n_evt - n0, 2);
    check("ferr_then_data", o_data, 8'h81);

    // Back-to-back frames, no idle gap
    n0 = n_evt;
    send_frame(8'h00, 1'b1, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 1'b1, 20);
    check("b2b_evt_count", n_evt - n0, 2);
    check("b2b_data", o_data, 8'hFF);

    // Reset 40 cycles into frame 0x55
    d = 8'h55;
    for (int c = 0; c < 40; c++) begin
      rx = (c < BD) ? 1'b0 : d[(c - BD) / BD];
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    check("midrst_data", o_data, 8'h00);
    check("midrst_dv", o_dv, 1'b0);
    check("midrst_busy", o_busy, 1'b0);
    check("midrst_frame_err", o_frame_err, 1'b0);
    check("midrst_parity_err", o_parity_err, 1'b0);
    rst = 1'b0;
    rx  = 1'b1;
    model_last = 8'h00;
    n0 = n_evt;
    repeat (30) @(negedge clk);
    check("midrst_no_evt", n_evt - n0, 0);
    send_frame(8'h12, 1'b1, 1'b1, 20);
    check("midrst_next_data", o_data, 8'h12);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 20);
    check("par_ok_data", o_data, 8'h07);
    send_frame(8'h07, 1'b1, 1'b0, 20);
    send_frame(8'h5A, 1'b0, 1'b0, 20);
`endif

    // Random frames
    for (int k = 0; k < 24; k++) begin
      d   = 8'($urandom);
      sok = ($urandom_range(0, 7) != 0);
`ifdef UART_RX_PARITY_EN
      pok = ($urandom_range(0, 5) != 0);
`else
      pok = 1'b1;
`endif
      gap = $urandom_range(0, 12);
      if (!sok) gap = gap + 3;
      send_frame(d, sok, pok, gap);
    end

    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_queue", exp_q.size(), 0);
    repeat (5) @(negedge clk);
    check("final_busy", o_busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation still running at %0t, limit 2000000", $time);
    $fatal(1, "tb_uart_rx_core time limit reached");
  end

endmodule
